board_controller: RTL and testbench

Game-state controller for the 3×3 grid overlay drawn by the VGA pixel path. It owns the board contents, cursor position, turn and win/draw status, and sequences every change so it happens only at a frame boundary. Debounced button pulses come in, and registered board state goes out to the renderer. It runs in the 25 MHz pixel-clock domain next to `vga_controller`.

---
 rtl/board_pkg.sv | 47 ++++
 rtl/board_line_eval.sv | 26 ++
 rtl/board_controller.sv | 148 ++++++++++++++
 tb/tb_board_controller.sv | 298 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/board_pkg.sv
// Shared types and constants for the 3x3 board controller: cell marks, game states,
// pending-command encoding, the winning-line table and the cursor wrap helper.
package board_pkg;

   typedef enum logic [1:0] {
      CellEmpty = 2'b00,
      CellX     = 2'b01,
      CellO     = 2'b10
   } cell_t;

   typedef enum logic [1:0] {
      StPlay  = 2'b00,
      StCheck = 2'b01,
      StWin   = 2'b10,
      StDraw  = 2'b11
   } game_state_t;

   typedef enum logic [2:0] {
      CmdNone,
      CmdUp,
      CmdDown,
      CmdLeft,
      CmdRight,
      CmdPlace
   } cmd_t;

   // Rows, then columns, then the two diagonals.
   localparam logic [3:0] LINES [8][3] = '{
      '{4'd0, 4'd1, 4'd2}, '{4'd3, 4'd4, 4'd5}, '{4'd6, 4'd7, 4'd8},
      '{4'd0, 4'd3, 4'd6}, '{4'd1, 4'd4, 4'd7}, '{4'd2, 4'd5, 4'd8},
      '{4'd0, 4'd4, 4'd8}, '{4'd2, 4'd4, 4'd6}
   };

   function automatic logic [3:0] move_cursor(input logic [3:0] cur, input cmd_t cmd);
      logic col0, col2;
      col0 = (cur == 4'd0) || (cur == 4'd3) || (cur == 4'd6);
      col2 = (cur == 4'd2) || (cur == 4'd5) || (cur == 4'd8);
      case (cmd)
         CmdUp:    return (cur < 4'd3) ? cur + 4'd6 : cur - 4'd3;
         CmdDown:  return (cur > 4'd5) ? cur - 4'd6 : cur + 4'd3;
         CmdLeft:  return col0 ? cur + 4'd2 : cur - 4'd1;
         CmdRight: return col2 ? cur - 4'd2 : cur + 4'd1;
         default:  return cur;
      endcase
   endfunction

endpackage

// File: rtl/board_line_eval.sv
// Combinational evaluation of one winning line: reports whether its three cells hold
// the same non-empty mark, and which mark that is.
module board_line_eval
   import board_pkg::*;
(
   input  logic [17:0] board,
   input  logic [2:0]  line_idx,
   output logic        match,
   output cell_t       owner
);

   logic [1:0] cells [9];
   logic [1:0] c0, c1, c2;

   always_comb begin
      for (int i = 0; i < 9; i++) begin
         cells[i] = board[2*i +: 2];
      end
      c0    = cells[LINES[line_idx][0]];
      c1    = cells[LINES[line_idx][1]];
      c2    = cells[LINES[line_idx][2]];
      match = (c0 != 2'b00) && (c0 == c1) && (c1 == c2);
      owner = cell_t'(c0);
   end

endmodule

// File: rtl/board_controller.sv
// Frame-gated tic-tac-toe state controller: latches button commands, applies them at
// frame_start, scans the eight lines after each place. BOARD_TURN_TIMER_EN adds a turn timer.
module board_controller
   import board_pkg::*;
#(
   parameter int unsigned TURN_FRAMES = 600
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        frame_start,
   input  logic        btn_up,
   input  logic        btn_down,
   input  logic        btn_left,
   input  logic        btn_right,
   input  logic        btn_place,
   output logic [17:0] board,
   output logic [3:0]  cursor,
   output logic        turn,
   output logic [1:0]  game_state,
   output logic [2:0]  win_line,
   output logic        busy
);

   game_state_t state_q;
   cmd_t        pend_q, btn_cmd;
   logic [17:0] board_q;
   logic [3:0]  cursor_q;
   logic        turn_q;
   logic [2:0]  win_line_q, line_idx_q;
   logic [1:0]  cur_cell;
   logic        board_full, place_ok, line_match;
   cell_t       line_owner;

`ifdef BOARD_TURN_TIMER_EN
   localparam int unsigned CntW = (TURN_FRAMES > 1) ? $clog2(TURN_FRAMES) : 1;
   localparam logic [CntW-1:0] CntLast = CntW'(TURN_FRAMES - 1);
   logic [CntW-1:0] frame_cnt_q;
`endif

   board_line_eval u_line_eval (
      .board    (board_q),
      .line_idx (line_idx_q),
      .match    (line_match),
      .owner    (line_owner)
   );

   always_comb begin
      btn_cmd = CmdNone;
      if (btn_place)      btn_cmd = CmdPlace;
      else if (btn_up)    btn_cmd = CmdUp;
      else if (btn_down)  btn_cmd = CmdDown;
      else if (btn_left)  btn_cmd = CmdLeft;
      else if (btn_right) btn_cmd = CmdRight;

      board_full = 1'b1;
      for (int i = 0; i < 9; i++) begin
         if (board_q[2*i +: 2] == 2'b00) board_full = 1'b0;
      end

      cur_cell = board_q[{cursor_q, 1'b0} +: 2];
      place_ok = frame_start && (state_q == StPlay) && (pend_q == CmdPlace) &&
                 (cur_cell == CellEmpty);
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q    <= StPlay;
         pend_q     <= CmdNone;
         board_q    <= '0;
         cursor_q   <= 4'd4;
         turn_q     <= 1'b0;
         win_line_q <= '0;
         line_idx_q <= '0;
`ifdef BOARD_TURN_TIMER_EN
         frame_cnt_q <= '0;
`endif
      end else begin
`ifdef BOARD_TURN_TIMER_EN
         // A place executing on the timeout frame takes precedence over the auto-pass.
         if ((state_q == StPlay) && frame_start && !place_ok) begin
            if (frame_cnt_q == CntLast) begin
               frame_cnt_q <= '0;
               turn_q      <= ~turn_q;
            end else begin
               frame_cnt_q <= frame_cnt_q + 1'b1;
            end
         end
         if (place_ok || ((state_q inside {StWin, StDraw}) && frame_start &&
                          (pend_q == CmdPlace))) begin
            frame_cnt_q <= '0;
         end
`endif
         unique case (state_q)
            StPlay: begin
               if (frame_start) begin
                  pend_q <= CmdNone;
                  if (place_ok) begin
                     board_q[{cursor_q, 1'b0} +: 2] <= turn_q ? CellO : CellX;
                     line_idx_q <= '0;
                     state_q    <= StCheck;
                  end else if (pend_q != CmdPlace) begin
                     cursor_q <= move_cursor(cursor_q, pend_q);
                  end
               end
            end
            StCheck: begin
               // Any new line must contain the mark just placed, so the owner is the mover.
               if (line_match && (line_owner == (turn_q ? CellO : CellX))) begin
                  state_q    <= StWin;
                  win_line_q <= line_idx_q;
               end else if (line_idx_q == 3'd7) begin
                  if (board_full) begin
                     state_q <= StDraw;
                  end else begin
                     state_q <= StPlay;
                     turn_q  <= ~turn_q;
                  end
               end else begin
                  line_idx_q <= line_idx_q + 3'd1;
               end
            end
            StWin, StDraw: begin
               if (frame_start) begin
                  pend_q <= CmdNone;
                  if (pend_q == CmdPlace) begin
                     board_q    <= '0;
                     turn_q     <= 1'b0;
                     cursor_q   <= 4'd4;
                     win_line_q <= '0;
                     state_q    <= StPlay;
                  end
               end
            end
            default: state_q <= StPlay;
         endcase
         // A fresh pulse always lands in the pending slot, even on an executing edge.
         if (btn_cmd != CmdNone) pend_q <= btn_cmd;
      end
   end

   assign board      = board_q;
   assign cursor     = cursor_q;
   assign turn       = turn_q;
   assign game_state = state_q;
   assign win_line   = win_line_q;
   assign busy       = (state_q == StCheck);

endmodule

// File: tb/tb_board_controller.sv
// Directed bench for board_controller: table of cursor moves plus hand sequences for
// gating, win, draw, mid-CHECK reset and (with BOARD_TURN_TIMER_EN) the turn timer.
module tb_board_controller;

`ifdef BOARD_TURN_TIMER_EN
   localparam int unsigned TurnFrames = 3;
`else
   localparam int unsigned TurnFrames = 600;
`endif

   localparam logic [4:0] BPlace = 5'b10000;
   localparam logic [4:0] BUp    = 5'b01000;
   localparam logic [4:0] BDown  = 5'b00100;
   localparam logic [4:0] BLeft  = 5'b00010;
   localparam logic [4:0] BRight = 5'b00001;

   logic        clk = 1'b0;
   logic        rst_n, frame_start;
   logic        btn_up, btn_down, btn_left, btn_right, btn_place;
   logic [17:0] board;
   logic [3:0]  cursor;
   logic        turn;
   logic [1:0]  game_state;
   logic [2:0]  win_line;
   logic        busy;

   int n_cmp = 0;
   int n_bad = 0;

   logic [17:0] m_board;
   logic [3:0]  m_cur;
   logic        m_turn;

   typedef struct {
      logic [4:0] btns;
      logic [3:0] exp_cur;
   } vec_t;
   vec_t vecs [16];

   board_controller #(.TURN_FRAMES(TurnFrames)) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .frame_start (frame_start),
      .btn_up      (btn_up),
      .btn_down    (btn_down),
      .btn_left    (btn_left),
      .btn_right   (btn_right),
      .btn_place   (btn_place),
      .board       (board),
      .cursor      (cursor),
      .turn        (turn),
      .game_state  (game_state),
      .win_line    (win_line),
      .busy        (busy)
   );

   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout, required $finish before 200us");
      $fatal(1);
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h required %0h", name, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic press(input logic [4:0] b);
      {btn_place, btn_up, btn_down, btn_left, btn_right} = b;
      step();
      {btn_place, btn_up, btn_down, btn_left, btn_right} = 5'b0;
   endtask

   task automatic frame();
      frame_start = 1'b1;
      step();
      frame_start = 1'b0;
   endtask

   task automatic move(input logic [4:0] b);
      press(b);
      frame();
   endtask

   task automatic check_reset(input string tag);
      check({tag, " board"}, 32'(board), 32'h0);
      check({tag, " cursor"}, 32'(cursor), 32'd4);
      check({tag, " turn"}, 32'(turn), 32'd0);
      check({tag, " state"}, 32'(game_state), 32'd0);
      check({tag, " win_line"}, 32'(win_line), 32'd0);
      check({tag, " busy"}, 32'(busy), 32'd0);
   endtask

   task automatic model_reset();
      m_board = '0;
      m_cur   = 4'd4;
      m_turn  = 1'b0;
   endtask

   // Walk the cursor to target (right along the row, then down the column) and place.
   task automatic place_at(input logic [3:0] target);
      int row, col;
      for (int k = 0; k < 8 && m_cur != target; k++) begin
         row = int'(m_cur) / 3;
         col = int'(m_cur) % 3;
         if (col != int'(target) % 3) begin
            move(BRight);
            m_cur = 4'((row * 3) + ((col + 1) % 3));
         end else begin
            move(BDown);
            m_cur = 4'((((row + 1) % 3) * 3) + col);
         end
      end
      press(BPlace);
      frame();
      m_board[2*target +: 2] = m_turn ? 2'b10 : 2'b01;
   endtask

   task automatic play(input logic [3:0] target);
      place_at(target);
      for (int k = 0; k < 8; k++) step();
      m_turn = ~m_turn;
      check("play state", 32'(game_state), 32'd0);
      check("play board", 32'(board), 32'(m_board));
      check("play turn", 32'(turn), 32'(m_turn));
   endtask

   initial begin
      vecs[0]  = '{BLeft, 4'd3};
      vecs[1]  = '{BLeft, 4'd5};
      vecs[2]  = '{BRight, 4'd3};
      vecs[3]  = '{BDown, 4'd6};
      vecs[4]  = '{BDown, 4'd0};
      vecs[5]  = '{BUp, 4'd6};
      vecs[6]  = '{BRight, 4'd7};
      vecs[7]  = '{BDown, 4'd1};
      vecs[8]  = '{BUp, 4'd7};
      vecs[9]  = '{BLeft, 4'd6};
      vecs[10] = '{BRight, 4'd7};
      vecs[11] = '{BUp, 4'd4};
      vecs[12] = '{BUp | BLeft, 4'd1};
      vecs[13] = '{BDown | BRight, 4'd4};
      vecs[14] = '{BLeft | BRight, 4'd3};
      vecs[15] = '{BRight, 4'd4};

      rst_n = 1'b0;
      frame_start = 1'b0;
      {btn_place, btn_up, btn_down, btn_left, btn_right} = 5'b0;
      step();
      step();
      check_reset("in reset");
      rst_n = 1'b1;
      step();
      check_reset("after reset");
      model_reset();

`ifdef BOARD_TURN_TIMER_EN
      frame();
      frame();
      check("timer two frames turn", 32'(turn), 32'd0);
      frame();
      check("timer third frame turn", 32'(turn), 32'd1);
      frame();
      frame();
      press(BPlace);
      frame();
      check("timer place wins turn", 32'(turn), 32'd1);
      check("timer place board", 32'(board), 32'h00200);
      check("timer place state", 32'(game_state), 32'd1);
      for (int k = 0; k < 8; k++) step();
      check("timer after check turn", 32'(turn), 32'd0);
      check("timer after check state", 32'(game_state), 32'd0);
      frame();
      frame();
      check("timer restart two frames", 32'(turn), 32'd0);
      frame();
      check("timer restart third frame", 32'(turn), 32'd1);
`else
      foreach (vecs[i]) begin
         move(vecs[i].btns);
         check($sformatf("move vec %0d cursor", i), 32'(cursor), 32'(vecs[i].exp_cur));
      end

      press(BLeft);
      press(BRight);
      frame();
      check("overwrite cursor", 32'(cursor), 32'd5);
      move(BLeft);
      check("overwrite back", 32'(cursor), 32'd4);

      btn_right = 1'b1;
      frame_start = 1'b1;
      step();
      btn_right = 1'b0;
      frame_start = 1'b0;
      check("same-cycle pulse waits", 32'(cursor), 32'd4);
      frame();
      check("same-cycle pulse next frame", 32'(cursor), 32'd5);
      move(BLeft);

      press(BPlace);
      step();
      step();
      step();
      check("gated board", 32'(board), 32'h0);
      check("gated state", 32'(game_state), 32'd0);
      frame();
      check("place board", 32'(board), 32'h00100);
      check("place state check", 32'(game_state), 32'd1);
      check("place busy", 32'(busy), 32'd1);
      for (int k = 0; k < 7; k++) step();
      check("check still busy M+7", 32'(game_state), 32'd1);
      step();
      check("check done state", 32'(game_state), 32'd0);
      check("check done turn", 32'(turn), 32'd1);
      check("check done busy", 32'(busy), 32'd0);

      press(BPlace);
      frame();
      check("occupied state", 32'(game_state), 32'd0);
      check("occupied board", 32'(board), 32'h00100);
      step();
      check("occupied turn", 32'(turn), 32'd1);

      rst_n = 1'b0;
      step();
      rst_n = 1'b1;
      check_reset("reset after place");
      model_reset();

      play(4'd0);
      play(4'd1);
      play(4'd4);
      play(4'd2);
      place_at(4'd8);
      for (int k = 0; k < 6; k++) step();
      check("win pending M+6", 32'(game_state), 32'd1);
      step();
      check("win state M+7", 32'(game_state), 32'd2);
      check("win line", 32'(win_line), 32'd6);
      check("win board", 32'(board), 32'(m_board));
      check("win busy", 32'(busy), 32'd0);
      move(BLeft);
      check("win ignores move cursor", 32'(cursor), 32'(m_cur));
      check("win ignores move state", 32'(game_state), 32'd2);
      move(BPlace);
      check_reset("restart from win");
      model_reset();

      play(4'd0);
      play(4'd1);
      play(4'd2);
      play(4'd4);
      play(4'd3);
      play(4'd5);
      play(4'd7);
      play(4'd6);
      place_at(4'd8);
      for (int k = 0; k < 7; k++) step();
      check("draw pending M+7", 32'(game_state), 32'd1);
      step();
      check("draw state", 32'(game_state), 32'd3);
      check("draw board", 32'(board), 32'(m_board));
      check("draw turn", 32'(turn), 32'd0);
      check("draw win_line", 32'(win_line), 32'd0);
      move(BPlace);
      check_reset("restart from draw");

      press(BPlace);
      frame();
      step();
      step();
      press(BLeft);
      check("mid-check busy", 32'(busy), 32'd1);
      rst_n = 1'b0;
      step();
      check_reset("mid-check reset");
      rst_n = 1'b1;
      frame();
      check("pending cleared by reset", 32'(cursor), 32'd4);
      check("no place after reset", 32'(board), 32'h0);
`endif

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
